// File: rtl/lisa_exec_sequencer.sv
// lisa_exec_sequencer: fetch/execute sequencer owning PC, inst_len and pred tag for the CFU.
// Optional per-instruction watchdog compiled in with `define LISA_SEQ_WATCHDOG_EN.
module lisa_exec_sequencer #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [15:0] WDOG_CYCLES = 16'd4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] start_pc,
  output logic        fetch_req,
  output logic [15:0] fetch_addr,
  input  logic        fetch_ack,
  input  logic [7:0]  fetch_len,
  output logic        exec_valid,
  input  logic        exec_done,
  input  logic [15:0] cfu_next_pc,
  input  logic        cfu_pred_tag_we,
  input  logic [7:0]  cfu_pred_tag_next,
  input  logic        cfu_halt,
  output logic [15:0] pc,
  output logic [7:0]  inst_len,
  output logic [7:0]  pred_tag,
  output logic        running,
  output logic        halted,
  output logic        fault,
  output logic        wdog_trip,
  output logic [31:0] retired
);
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, HALTED, FAULT} state_t;
  state_t state, state_nx;
  logic launch, commit, wdog_exp;
  assign running    = state == FETCH || state == EXEC;
  assign halted     = state == HALTED;
  assign fault      = state == FAULT;
  assign fetch_addr = pc;
  assign launch     = !running && start;
  assign commit     = state == EXEC && exec_done;
`ifdef LISA_SEQ_WATCHDOG_EN
  logic [15:0] wdog_cnt;
  assign wdog_exp = running && !commit && wdog_cnt == WDOG_CYCLES - 16'd1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wdog_cnt <= '0;
    else wdog_cnt <= (state_nx == FETCH && state != FETCH) ? '0 : running ? wdog_cnt + 16'd1 : wdog_cnt;
`else
  assign wdog_exp = 1'b0 & |WDOG_CYCLES;
`endif
  always_comb begin
    state_nx = state;
    if (launch) state_nx = FETCH;
    else if (wdog_exp) state_nx = FAULT;
    else if (state == FETCH && fetch_ack) state_nx = fetch_len == '0 ? FAULT : EXEC;
    else if (commit) state_nx = cfu_halt ? HALTED : FETCH;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      fetch_req  <= 1'b0;
      exec_valid <= 1'b0;
      pc         <= RESET_PC;
      inst_len   <= '0;
      pred_tag   <= '0;
      retired    <= '0;
      wdog_trip  <= 1'b0;
    end else begin
      state      <= state_nx;
      fetch_req  <= state_nx == FETCH;
      exec_valid <= state_nx == EXEC;
      wdog_trip  <= launch ? 1'b0 : wdog_trip | wdog_exp;
      if (launch) begin
        pc       <= start_pc;
        pred_tag <= '0;
        retired  <= '0;
      end
      if (state == FETCH && fetch_ack && fetch_len != '0 && !wdog_exp) inst_len <= fetch_len;
      if (commit) begin
        retired <= &retired ? retired : retired + 32'd1;
        if (!cfu_halt) begin
          pc <= cfu_next_pc;
          if (cfu_pred_tag_we) pred_tag <= cfu_pred_tag_next;
        end
      end
    end
  end
endmodule
